// File: rtl/count_pkg.sv
// Shared types and helpers for the parametrised up/down counter family.
package count_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } count_mode_e;

    // Out-of-range load values are pinned to the top of the count range.
    function automatic longint unsigned clamp_load(
        input longint unsigned d,
        input longint unsigned modulus
    );
        return (d < modulus) ? d : (modulus - 64'd1);
    endfunction

endpackage

// File: rtl/count_next_logic.sv
// Pure combinational next-state, wrap-event and terminal-count logic.
module count_next_logic
    import count_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter count_mode_e     MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sclr_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             wrap_next_o,
    output logic             tc_o
);

    // One extra bit so increments and the load clamp never overflow silently.
    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 64'd1);
    localparam logic [WIDTH:0] ONE_V = (WIDTH+1)'(1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] load_ext;
    logic [WIDTH:0] next_ext;
    logic           at_max;
    logic           at_zero;

    assign q_ext    = {1'b0, q_i};
    assign load_ext = (WIDTH+1)'(clamp_load(64'(d_i), MODULUS));
    assign at_max   = (q_ext == MAX_V);
    assign at_zero  = (q_ext == '0);

    always_comb begin
        next_ext    = q_ext;
        wrap_next_o = 1'b0;
        if (sclr_i) begin
            next_ext = '0;
        end else if (load_i) begin
            next_ext = load_ext;
        end else if (en_i) begin
            if (up_i) begin
                if (!at_max) begin
                    next_ext = q_ext + ONE_V;
                end else if (MODE == CNT_WRAP) begin
                    next_ext    = '0;
                    wrap_next_o = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    next_ext = q_ext - ONE_V;
                end else if (MODE == CNT_WRAP) begin
                    next_ext    = MAX_V;
                    wrap_next_o = 1'b1;
                end
            end
        end
    end

    // Guard keeps the register inside 0..MODULUS-1 even if Q was ever corrupted.
    assign q_next_o = (next_ext > MAX_V) ? MAX_V[WIDTH-1:0] : next_ext[WIDTH-1:0];

    assign tc_o = up_i ? at_max : at_zero;

endmodule

// File: rtl/count_nbits_updown.sv
// Parametrised up/down counter with load, sync clear, wrap/saturate and cascade outputs.
module count_nbits_updown
    import count_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             Clear_n,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Sclr,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Co,
    output logic             Wrap
);

    localparam count_mode_e MODE = SATURATE ? CNT_SAT : CNT_WRAP;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             tc;

    count_next_logic #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .MODE    (MODE)
    ) u_next (
        .q_i         (q_q),
        .en_i        (En),
        .up_i        (Up),
        .load_i      (Load),
        .d_i         (D),
        .sclr_i      (Sclr),
        .q_next_o    (q_d),
        .wrap_next_o (wrap_d),
        .tc_o        (tc)
    );

    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Co is masked by Load/Sclr so a downstream stage never steps on a non-count edge.
    assign Q    = q_q;
    assign Tc   = tc;
    assign Co   = tc & En & ~Load & ~Sclr;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_count_nbits_updown.sv
// Directed self-checking bench for count_nbits_updown (wrap, saturate, cascade, modulus-2).
module tb_count_nbits_updown;

    logic clk = 1'b0;
    logic clr_n = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    // Instance A: WIDTH=4, MODULUS=10, wrap mode
    logic       a_en = 0, a_up = 1, a_load = 0, a_sclr = 0;
    logic [3:0] a_d = '0;
    logic [3:0] a_q;
    logic       a_tc, a_co, a_wrap;

    count_nbits_updown #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_a (
        .clk(clk), .Clear_n(clr_n), .En(a_en), .Up(a_up), .Load(a_load), .D(a_d),
        .Sclr(a_sclr), .Q(a_q), .Tc(a_tc), .Co(a_co), .Wrap(a_wrap)
    );

    // Instance S: WIDTH=4, MODULUS=10, saturate mode
    logic       s_en = 0, s_up = 1;
    logic [3:0] s_q;
    logic       s_tc, s_co, s_wrap;

    count_nbits_updown #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b1)) u_s (
        .clk(clk), .Clear_n(clr_n), .En(s_en), .Up(s_up), .Load(1'b0), .D(4'd0),
        .Sclr(1'b0), .Q(s_q), .Tc(s_tc), .Co(s_co), .Wrap(s_wrap)
    );

    // Cascade: two BCD digits, low Co drives high En
    logic       c_en = 0;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, lo_co, lo_wrap, hi_tc, hi_co, hi_wrap;

    count_nbits_updown #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_lo (
        .clk(clk), .Clear_n(clr_n), .En(c_en), .Up(1'b1), .Load(1'b0), .D(4'd0),
        .Sclr(1'b0), .Q(lo_q), .Tc(lo_tc), .Co(lo_co), .Wrap(lo_wrap)
    );

    count_nbits_updown #(.WIDTH(4), .MODULUS(64'd10), .SATURATE(1'b0)) u_hi (
        .clk(clk), .Clear_n(clr_n), .En(lo_co), .Up(1'b1), .Load(1'b0), .D(4'd0),
        .Sclr(1'b0), .Q(hi_q), .Tc(hi_tc), .Co(hi_co), .Wrap(hi_wrap)
    );

    // Instance M: WIDTH=1, MODULUS=2
    logic m_en = 0;
    logic m_q, m_tc, m_co, m_wrap;

    count_nbits_updown #(.WIDTH(1), .MODULUS(64'd2), .SATURATE(1'b0)) u_m (
        .clk(clk), .Clear_n(clr_n), .En(m_en), .Up(1'b1), .Load(1'b0), .D(1'b0),
        .Sclr(1'b0), .Q(m_q), .Tc(m_tc), .Co(m_co), .Wrap(m_wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 clr_n = 1'b0;
        #1;
        total_cnt++;
        if ({a_q, a_wrap, s_q, lo_q, hi_q, m_q} !== 18'd0) $display("FAIL reset_async a_q=%0d a_wrap=%0b s_q=%0d lo=%0d hi=%0d m=%0b expected all 0", a_q, a_wrap, s_q, lo_q, hi_q, m_q);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({a_q, a_wrap} !== 5'd0) $display("FAIL reset_held a_q=%0d a_wrap=%0b expected 0 0", a_q, a_wrap);
        else pass_cnt++;
        clr_n = 1'b1;
        $display("reset: Q=%0d Wrap=%0b", a_q, a_wrap);
    endtask

    task automatic test_count_up();
        a_en = 1'b1;
        a_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if (a_q !== 4'(i) || a_tc !== (i == 9) || a_co !== (i == 9) || a_wrap !== 1'b0)
                $display("FAIL count_up step %0d: Q=%0d Tc=%0b Co=%0b Wrap=%0b expected Q=%0d Tc=%0b Co=%0b Wrap=0",
                         i, a_q, a_tc, a_co, a_wrap, i, (i == 9), (i == 9));
            else pass_cnt++;
            $display("count_up: Q=%0d Tc=%0b Co=%0b", a_q, a_tc, a_co);
            tick();
        end
        total_cnt++;
        if (a_q !== 4'd0 || a_wrap !== 1'b1) $display("FAIL up_wrap Q=%0d Wrap=%0b expected Q=0 Wrap=1", a_q, a_wrap);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (a_q !== 4'd1 || a_wrap !== 1'b0) $display("FAIL up_wrap_clear Q=%0d Wrap=%0b expected Q=1 Wrap=0", a_q, a_wrap);
        else pass_cnt++;
    endtask

    task automatic test_count_down();
        a_up = 1'b0;
        #1;
        total_cnt++;
        if (a_tc !== 1'b0) $display("FAIL down_tc_at1 Tc=%0b expected 0", a_tc);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (a_q !== 4'd0 || a_tc !== 1'b1 || a_co !== 1'b1 || a_wrap !== 1'b0)
            $display("FAIL down_at0 Q=%0d Tc=%0b Co=%0b Wrap=%0b expected Q=0 Tc=1 Co=1 Wrap=0", a_q, a_tc, a_co, a_wrap);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (a_q !== 4'd9 || a_wrap !== 1'b1 || a_tc !== 1'b0)
            $display("FAIL down_wrap Q=%0d Wrap=%0b Tc=%0b expected Q=9 Wrap=1 Tc=0", a_q, a_wrap, a_tc);
        else pass_cnt++;
        // Direction flip at the top end: Tc follows Up without a clock edge
        a_up = 1'b1;
        #1;
        total_cnt++;
        if (a_tc !== 1'b1 || a_q !== 4'd9) $display("FAIL dir_flip_tc Tc=%0b Q=%0d expected Tc=1 Q=9", a_tc, a_q);
        else pass_cnt++;
        a_up = 1'b0;
        tick();
        total_cnt++;
        if (a_q !== 4'd8 || a_wrap !== 1'b0) $display("FAIL down_8 Q=%0d Wrap=%0b expected Q=8 Wrap=0", a_q, a_wrap);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (a_q !== 4'd7 || a_tc !== 1'b0) $display("FAIL down_7 Q=%0d Tc=%0b expected Q=7 Tc=0", a_q, a_tc);
        else pass_cnt++;
        $display("count_down: Q=%0d", a_q);
    endtask

    task automatic test_saturate();
        int wrap_seen = 0;
        s_en = 1'b1;
        s_up = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (s_wrap) wrap_seen++;
        end
        total_cnt++;
        if (s_q !== 4'd9 || s_tc !== 1'b1) $display("FAIL sat_hold_top Q=%0d Tc=%0b expected Q=9 Tc=1", s_q, s_tc);
        else pass_cnt++;
        s_up = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (s_wrap) wrap_seen++;
        end
        total_cnt++;
        if (s_q !== 4'd0 || s_tc !== 1'b1) $display("FAIL sat_hold_bottom Q=%0d Tc=%0b expected Q=0 Tc=1", s_q, s_tc);
        else pass_cnt++;
        total_cnt++;
        if (wrap_seen !== 0) $display("FAIL sat_no_wrap wrap pulses=%0d expected 0", wrap_seen);
        else pass_cnt++;
        s_en = 1'b0;
        $display("saturate: Q=%0d wrap pulses=%0d", s_q, wrap_seen);
    endtask

    task automatic test_load();
        a_en = 1'b1;
        a_up = 1'b1;
        a_load = 1'b1;
        a_d = 4'd7;
        tick();
        total_cnt++;
        if (a_q !== 4'd7) $display("FAIL load_7 Q=%0d expected 7", a_q);
        else pass_cnt++;
        a_d = 4'd13;
        tick();
        total_cnt++;
        if (a_q !== 4'd9 || a_wrap !== 1'b0) $display("FAIL load_clamp Q=%0d Wrap=%0b expected Q=9 Wrap=0", a_q, a_wrap);
        else pass_cnt++;
        total_cnt++;
        if (a_tc !== 1'b1 || a_co !== 1'b0) $display("FAIL load_co_mask Tc=%0b Co=%0b expected Tc=1 Co=0", a_tc, a_co);
        else pass_cnt++;
        a_sclr = 1'b1;
        #1;
        total_cnt++;
        if (a_co !== 1'b0) $display("FAIL sclr_co_mask Co=%0b expected 0", a_co);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (a_q !== 4'd0 || a_wrap !== 1'b0) $display("FAIL sclr_priority Q=%0d Wrap=%0b expected Q=0 Wrap=0", a_q, a_wrap);
        else pass_cnt++;
        a_sclr = 1'b0;
        a_load = 1'b0;
        $display("load: Q=%0d", a_q);
    endtask

    task automatic test_async_reset();
        a_en = 1'b1;
        a_up = 1'b1;
        a_load = 1'b1;
        a_d = 4'd6;
        tick();
        a_load = 1'b0;
        total_cnt++;
        if (a_q !== 4'd6) $display("FAIL pre_reset Q=%0d expected 6", a_q);
        else pass_cnt++;
        #1 clr_n = 1'b0;
        #1;
        total_cnt++;
        if (a_q !== 4'd0 || a_wrap !== 1'b0) $display("FAIL mid_reset Q=%0d Wrap=%0b expected Q=0 Wrap=0", a_q, a_wrap);
        else pass_cnt++;
        #1 clr_n = 1'b1;
        tick();
        total_cnt++;
        if (a_q !== 4'd1) $display("FAIL resume_after_reset Q=%0d expected 1", a_q);
        else pass_cnt++;
        a_en = 1'b0;
        $display("async_reset: Q=%0d", a_q);
    endtask

    task automatic test_cascade();
        int hi_wraps = 0;
        int bad = 0;
        c_en = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (hi_wrap) hi_wraps++;
            if (hi_q !== 4'((n % 100) / 10) || lo_q !== 4'(n % 10)) bad++;
            if (n == 99) begin
                total_cnt++;
                if (hi_q !== 4'd9 || lo_q !== 4'd9) $display("FAIL cascade_99 reads %0d%0d expected 99", hi_q, lo_q);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (hi_q !== 4'd0 || lo_q !== 4'd0 || hi_wrap !== 1'b1)
            $display("FAIL cascade_rollover reads %0d%0d hi Wrap=%0b expected 00 Wrap=1", hi_q, lo_q, hi_wrap);
        else pass_cnt++;
        total_cnt++;
        if (hi_wraps !== 1) $display("FAIL cascade_hi_wrap_count pulses=%0d expected 1", hi_wraps);
        else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL cascade_sequence wrong steps=%0d expected 0", bad);
        else pass_cnt++;
        c_en = 1'b0;
        $display("cascade: reads %0d%0d hi wraps=%0d", hi_q, lo_q, hi_wraps);
    endtask

    task automatic test_mod2();
        m_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++;
            if (m_q !== 1'(i % 2) || m_wrap !== (i % 2 == 0))
                $display("FAIL mod2 step %0d Q=%0b Wrap=%0b expected Q=%0b Wrap=%0b", i, m_q, m_wrap, 1'(i % 2), (i % 2 == 0));
            else pass_cnt++;
        end
        m_en = 1'b0;
        $display("mod2: Q=%0b Wrap=%0b", m_q, m_wrap);
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load();
        test_async_reset();
        test_cascade();
        test_mod2();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/count_nbits_updown.md
# count_nbits_updown

Parametrised synchronous up/down counter: the general-purpose successor to the fixed 4-bit enable counter. It adds configurable width and modulus, direction control, parallel load, a synchronous clear, and wrap or saturate mode. Terminal-count and carry-out are provided so several instances can be cascaded into wider or mixed-radix counters, for example BCD digits or clock dividers. It sits in the sequential-circuits library beside the existing counters and flip-flop cells.

## Interface
- WIDTH, 4: counter width in bits, at least 1.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; must satisfy 2 ≤ MODULUS ≤ 2**WIDTH.
- SATURATE, 0: 0 = wrap at the range ends; 1 = hold at the range ends.

- clk  in  1  clock; all state updates on the rising edge.
- Clear_n  in  1  asynchronous, active-low reset.
- En  in  1  count enable.
- Up  in  1  direction: 1 = increment, 0 = decrement.
- Load  in  1  synchronous parallel load.
- D  in  WIDTH  load value.
- Sclr  in  1  synchronous clear to 0.
- Q  out  WIDTH  count value (registered).
- Tc  out  1  terminal count, combinational from Q and Up.
- Co  out  1  cascade carry/borrow: Co = Tc & En & ~Load & ~Sclr.
- Wrap  out  1  registered one-cycle pulse, asserted the cycle after a wrap occurs.

## Operation
- Reset (Clear_n = 0, asynchronous):
  - Q = 0 and Wrap = 0 immediately, held while low.
  - Release is synchronous to the next clk edge.
- Per rising edge, priority order Sclr > Load > En:
  - Sclr = 1: Q ← 0.
  - Load = 1: Q ← D if D < MODULUS, else Q ← MODULUS-1 (clamped).
  - En = 1, Up = 1: Q ← Q+1 when Q ≠ MODULUS-1. At MODULUS-1: Q ← 0 if SATURATE = 0, else Q holds.
  - En = 1, Up = 0: Q ← Q-1 when Q ≠ 0. At 0: Q ← MODULUS-1 if SATURATE = 0, else Q holds.
  - En = 0: Q holds.
- Tc = (Up & Q == MODULUS-1) | (~Up & Q == 0). Tc is independent of En.
- Wrap:
  - Set for exactly one cycle when the previous edge performed a count-wrap (SATURATE = 0 only).
  - Never set by Load or Sclr.
  - Never set when SATURATE = 1.
- Arithmetic:
  - Internal next-value computation uses WIDTH+1 bits, so no overflow is hidden.
  - Q is always within 0..MODULUS-1 after any edge.
- Direction change while at an end: Tc re-evaluates combinationally with the new Up. No state change occurs without a clock edge.
- Cascade rule: the En of stage k+1 is driven by Co of stage k. The chain forms a synchronous counter with no ripple clocking.

## Timing
- Latency: one clk edge from any control input to Q. Tc and Co are combinational in the same cycle.
- Wrap is valid during the cycle following the wrapping edge and is cleared on the next edge unless another wrap occurs.
- With MODULUS = 2 and SATURATE = 0, continuous counting gives Wrap high on alternate cycles.
- Reset mid-count: Q is forced to 0 asynchronously, with no glitch to other values. The first count after release occurs on the first edge with Clear_n = 1.
- Simultaneous Sclr, Load and En: Sclr wins. Co is suppressed so downstream stages do not count.
- Single clock domain. No combinational path from D to any output.

## Structure
- Shared package count_pkg holds:
  - typedef count_mode_e {CNT_WRAP, CNT_SAT}, mapped to SATURATE.
  - The function clamp_load(D, MODULUS).
- Natural sub-module: count_next_logic, a pure combinational next-state and terminal-count computation. The top level holds only the Q/Wrap register with async clear and the output assignments.
- No T-flip-flop cells. The state is a single WIDTH-bit register.

## Test plan
- WIDTH=4, MODULUS=10, SATURATE=0, Up=1, En=1 from reset → Q steps 0..9.
  - Tc=1 and Co=1 at Q=9.
  - Q=0 on the next edge, with Wrap=1 for one cycle.
- Same configuration, Up=0 from Q=0 → Q=9 on the first edge with Wrap=1, then 8, 7, … Tc=1 only at Q=0.
- SATURATE=1, MODULUS=10: count up to 9 and hold for 5 more edges → Q stays 9, Tc=1, Wrap never set. Same at 0 when counting down.
- Load tests:
  - Load=1, D=7 → Q=7.
  - D=13 → Q=9 (clamped).
  - Sclr=1, Load=1, En=1 together → Q=0 and Co=0.
- Reset mid-operation: Clear_n pulsed low between edges at Q=6 → Q=0 and Wrap=0 immediately. Counting resumes 0→1 on the first edge after release.
- Cascade of two instances, MODULUS=10 each (Co of the low digit drives En of the high digit), counting up from 00 for 100 edges → reads 99, then 00. The high digit's Wrap pulses once, at the 00 rollover.
